div_restoring_16b: RTL



---
 rtl/div_restoring_16b_if.sv | 13 +
 rtl/div_restoring_16b.sv | 65 ++++++
 2 files changed

// File: rtl/div_restoring_16b_if.sv
// div_restoring_16b_if: start/busy/done handshake and operand/result bus for the divider.
interface div_restoring_16b_if #(parameter int WIDTH = 16);
   logic             start;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   modport master (output start, inA, inB, input quot, rem, busy, done, div_by_zero);
   modport slave (input start, inA, inB, output quot, rem, busy, done, div_by_zero);
endinterface

// File: rtl/div_restoring_16b.sv
// div_restoring_16b: sequential unsigned restoring divider, one quotient bit per clock.
module div_restoring_16b #(parameter int WIDTH = 16) (
   input logic clk,
   input logic rst,
   div_restoring_16b_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] dvd, dvs, prem, quot_r, rem_r;
   logic [CW-1:0] cnt;
   logic [WIDTH:0] s, t;
   logic nb, accept, last, dbz_r;
   // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
   assign s = {prem, dvd[WIDTH-1]};
   assign t = s - {1'b0, dvs};
   assign nb = ~t[WIDTH];
   assign accept = bus.start && state != RUN;
   assign last = cnt == CW'(WIDTH - 1);
   always_comb begin
      state_nx = state;
      if (state == RUN)
         state_nx = last ? DONE : RUN;
      else
         state_nx = accept ? (bus.inB == '0 ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         dvd <= '0;
         dvs <= '0;
         prem <= '0;
         cnt <= '0;
         quot_r <= '0;
         rem_r <= '0;
         dbz_r <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept && bus.inB == '0) begin
            quot_r <= '1;
            rem_r <= bus.inA;
            dbz_r <= 1'b1;
         end else if (accept) begin
            dvd <= bus.inA;
            dvs <= bus.inB;
            prem <= '0;
            cnt <= '0;
            dbz_r <= 1'b0;
         end else if (state == RUN) begin
            prem <= nb ? t[WIDTH-1:0] : s[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], nb};
            cnt <= cnt + CW'(1);
            if (last) begin
               quot_r <= {dvd[WIDTH-2:0], nb};
               rem_r <= nb ? t[WIDTH-1:0] : s[WIDTH-1:0];
            end
         end
      end
   end
   assign bus.quot = quot_r;
   assign bus.rem = rem_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
endmodule
